control_sequencer: RTL and testbench

//   Hardwired control FSM that drives every control input of the datapath: GPR enables, bus-out selects, ALU op strobes and memory handshake.

---
 rtl/control_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired fetch/execute control FSM for the 32-bit datapath.
//               Drives GPR enables, bus selects, ALU strobes and memory
//               handshake, decoding the opcode returned on IRVal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int SIG_COUNT = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS-1:0]      IRVal,
    input  logic                 mem_ready,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 PCin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 MARin,
    output logic                 HILOin,
    output logic                 MDRin,
    output logic                 OUTPUTin,
    output logic                 PCout,
    output logic                 RZout,
    output logic                 MDRout,
    output logic                 HILOout,
    output logic                 INPUTout,
    output logic                 BAout,
    output logic                 Cout,
    output logic                 Read,
    output logic                 mem_write,
    output logic [SIG_COUNT-1:0] alu_ctrl,
    output logic                 halted
);

    localparam logic [3:0] c_T0   = 4'd0;
    localparam logic [3:0] c_T1   = 4'd1;
    localparam logic [3:0] c_T2   = 4'd2;
    localparam logic [3:0] c_T3   = 4'd3;
    localparam logic [3:0] c_T4   = 4'd4;
    localparam logic [3:0] c_T5   = 4'd5;
    localparam logic [3:0] c_T6   = 4'd6;
    localparam logic [3:0] c_T7   = 4'd7;
    localparam logic [3:0] c_HALT = 4'd8;

    // alu_ctrl bit positions, MSB..LSB = IncPC,NOT,NEGATE,OR,AND,ROL,ROR,SHL,SHR,DIV,MUL,SUB,ADD
    localparam int c_ADD = 0;
    localparam int c_SUB = 1;
    localparam int c_MUL = 2;
    localparam int c_DIV = 3;
    localparam int c_SHR = 4;
    localparam int c_SHL = 5;
    localparam int c_ROR = 6;
    localparam int c_ROL = 7;
    localparam int c_AND = 8;
    localparam int c_OR  = 9;
    localparam int c_NEG = 10;
    localparam int c_NOT = 11;
    localparam int c_INC = 12;

    localparam logic [SIG_COUNT-1:0] c_ONE_ALU = SIG_COUNT'(1);
    localparam logic [REGISTERS-1:0] c_ONE_REG = REGISTERS'(1);

    logic [3:0]           r_state;
    logic [3:0]           w_next;
    logic [4:0]           r_op;
    logic [4:0]           w_ir_op;
    logic                 w_ir_defined;
    logic                 w_is_rrr, w_is_imm, w_is_md, w_is_un;
    logic                 w_is_ld, w_is_ldi, w_is_st, w_is_mem, w_is_in, w_is_out;
    logic [SIG_COUNT-1:0] w_alu_op;
    logic [1:0]           w_gsel;
    logic                 w_rin, w_rout, w_ba;
    logic [REGISTERS-1:0] w_dec;
    logic                 w_unused_ir;

    assign w_ir_op      = IRVal[31:27];
    assign w_ir_defined = (w_ir_op <= 5'd17) || (w_ir_op == 5'd22) || (w_ir_op == 5'd23);
    assign w_unused_ir  = ^IRVal[14:0];

    assign w_is_ld  = (r_op == 5'd0);
    assign w_is_ldi = (r_op == 5'd1);
    assign w_is_st  = (r_op == 5'd2);
    assign w_is_mem = (r_op <= 5'd2);
    assign w_is_rrr = (r_op >= 5'd3)  && (r_op <= 5'd10);
    assign w_is_imm = (r_op >= 5'd11) && (r_op <= 5'd13);
    assign w_is_md  = (r_op == 5'd14) || (r_op == 5'd15);
    assign w_is_un  = (r_op == 5'd16) || (r_op == 5'd17);
    assign w_is_in  = (r_op == 5'd22);
    assign w_is_out = (r_op == 5'd23);

    always_comb begin
        w_alu_op = '0;
        case (r_op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd11: w_alu_op = c_ONE_ALU << c_ADD;
            5'd4:         w_alu_op = c_ONE_ALU << c_SUB;
            5'd5, 5'd12:  w_alu_op = c_ONE_ALU << c_AND;
            5'd6, 5'd13:  w_alu_op = c_ONE_ALU << c_OR;
            5'd7:         w_alu_op = c_ONE_ALU << c_ROR;
            5'd8:         w_alu_op = c_ONE_ALU << c_ROL;
            5'd9:         w_alu_op = c_ONE_ALU << c_SHR;
            5'd10:        w_alu_op = c_ONE_ALU << c_SHL;
            5'd14:        w_alu_op = c_ONE_ALU << c_MUL;
            5'd15:        w_alu_op = c_ONE_ALU << c_DIV;
            5'd16:        w_alu_op = c_ONE_ALU << c_NEG;
            5'd17:        w_alu_op = c_ONE_ALU << c_NOT;
            default:      w_alu_op = '0;
        endcase
    end

    // Gra/Grb/Grc: register fields come from the IR held stable by the datapath
    always_comb begin
        case (w_gsel)
            2'd0:    w_dec = c_ONE_REG << IRVal[26:23];
            2'd1:    w_dec = c_ONE_REG << IRVal[22:19];
            2'd2:    w_dec = c_ONE_REG << IRVal[18:15];
            default: w_dec = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_T0;
            r_op    <= 5'd0;
        end else begin
            r_state <= w_next;
            if (r_state == c_T2) begin
                r_op <= w_ir_op;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_gsel    = 2'd0;
        w_rin     = 1'b0;
        w_rout    = 1'b0;
        w_ba      = 1'b0;
        PCin      = 1'b0;
        IRin      = 1'b0;
        RYin      = 1'b0;
        RZin      = 1'b0;
        MARin     = 1'b0;
        HILOin    = 1'b0;
        MDRin     = 1'b0;
        OUTPUTin  = 1'b0;
        PCout     = 1'b0;
        RZout     = 1'b0;
        MDRout    = 1'b0;
        HILOout   = 1'b0;
        INPUTout  = 1'b0;
        Cout      = 1'b0;
        Read      = 1'b0;
        mem_write = 1'b0;
        alu_ctrl  = '0;
        halted    = 1'b0;
        // reset forces every strobe low so a mid-instruction abort writes nothing back
        if (!reset) begin
            case (r_state)
                c_T0: begin
                    PCout    = 1'b1;
                    MARin    = 1'b1;
                    alu_ctrl = c_ONE_ALU << c_INC;
                    RZin     = 1'b1;
                    w_next   = c_T1;
                end
                c_T1: begin
                    RZout = 1'b1;
                    PCin  = 1'b1;
                    Read  = 1'b1;
                    MDRin = 1'b1;
                    if (mem_ready) w_next = c_T2;
                end
                c_T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                    if (w_ir_op == 5'd27)  w_next = c_HALT;
                    else if (w_ir_defined) w_next = c_T3;
                    else                   w_next = c_T0;
                end
                c_T3: begin
                    w_next = c_T4;
                    if (w_is_in) begin
                        INPUTout = 1'b1;
                        w_rin    = 1'b1;
                        w_next   = c_T0;
                    end else if (w_is_out) begin
                        w_rout   = 1'b1;
                        OUTPUTin = 1'b1;
                        w_next   = c_T0;
                    end else if (w_is_rrr || w_is_imm) begin
                        w_gsel = 2'd1;
                        w_rout = 1'b1;
                        RYin   = 1'b1;
                    end else if (w_is_md) begin
                        w_rout = 1'b1;
                        RYin   = 1'b1;
                    end else if (w_is_un) begin
                        w_gsel   = 2'd1;
                        w_rout   = 1'b1;
                        alu_ctrl = w_alu_op;
                        RZin     = 1'b1;
                    end else if (w_is_mem) begin
                        w_gsel = 2'd1;
                        w_ba   = 1'b1;
                        RYin   = 1'b1;
                    end else begin
                        w_next = c_T0;
                    end
                end
                c_T4: begin
                    w_next = c_T5;
                    if (w_is_rrr) begin
                        w_gsel   = 2'd2;
                        w_rout   = 1'b1;
                        alu_ctrl = w_alu_op;
                        RZin     = 1'b1;
                    end else if (w_is_imm || w_is_mem) begin
                        Cout     = 1'b1;
                        alu_ctrl = w_alu_op;
                        RZin     = 1'b1;
                    end else if (w_is_md) begin
                        w_gsel   = 2'd1;
                        w_rout   = 1'b1;
                        alu_ctrl = w_alu_op;
                        RZin     = 1'b1;
                    end else if (w_is_un) begin
                        RZout  = 1'b1;
                        w_rin  = 1'b1;
                        w_next = c_T0;
                    end else begin
                        w_next = c_T0;
                    end
                end
                c_T5: begin
                    w_next = c_T0;
                    if (w_is_rrr || w_is_imm || w_is_ldi) begin
                        RZout = 1'b1;
                        w_rin = 1'b1;
                    end else if (w_is_md) begin
                        RZout  = 1'b1;
                        HILOin = 1'b1;
                    end else if (w_is_ld || w_is_st) begin
                        RZout  = 1'b1;
                        MARin  = 1'b1;
                        w_next = c_T6;
                    end
                end
                c_T6: begin
                    w_next = c_T0;
                    if (w_is_ld) begin
                        Read   = 1'b1;
                        MDRin  = 1'b1;
                        w_next = mem_ready ? c_T7 : c_T6;
                    end else if (w_is_st) begin
                        w_rout = 1'b1;
                        MDRin  = 1'b1;
                        w_next = c_T7;
                    end
                end
                c_T7: begin
                    w_next = c_T0;
                    if (w_is_ld) begin
                        MDRout = 1'b1;
                        w_rin  = 1'b1;
                    end else if (w_is_st) begin
                        mem_write = 1'b1;
                        w_next    = mem_ready ? c_T0 : c_T7;
                    end
                end
                c_HALT: begin
                    halted = 1'b1;
                    w_next = c_HALT;
                end
                default: w_next = c_T0;
            endcase
        end
        BAout  = w_ba;
        GPRin  = w_rin ? w_dec : '0;
        GPRout = (w_rout || w_ba) ? w_dec : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer against a
//               micro-step queue model of the fetch/execute sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] gin;
        logic [15:0] gout;
        logic pcin, irin, ryin, rzin, marin, hiloin, mdrin, outin;
        logic pcout, rzout, mdrout, hiloout, inpout, baout, cout;
        logic rd, mw;
        logic [12:0] alu;
        logic halted;
    } outs_t;

    // tag: 1 = first fetch step, 2 = last fetch step (opcode decided here), 0 = other
    typedef struct {
        outs_t o;
        bit    wt;
        int    tag;
    } step_t;

    localparam int A_ADD = 0, A_SUB = 1, A_MUL = 2, A_DIV = 3, A_SHR = 4, A_SHL = 5,
                   A_ROR = 6, A_ROL = 7, A_AND = 8, A_OR = 9, A_NEG = 10, A_NOT = 11,
                   A_INC = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IRVal = '0;
    logic        mem_ready = 1'b1;
    logic [15:0] GPRin, GPRout;
    logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin;
    logic PCout, RZout, MDRout, HILOout, INPUTout, BAout, Cout;
    logic Read, mem_write, halted;
    logic [12:0] alu_ctrl;

    control_sequencer #(.BITS(32), .REGISTERS(16), .SIG_COUNT(13)) dut (
        .clk(clk), .reset(reset), .IRVal(IRVal), .mem_ready(mem_ready),
        .GPRin(GPRin), .GPRout(GPRout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .HILOin(HILOin), .MDRin(MDRin), .OUTPUTin(OUTPUTin),
        .PCout(PCout), .RZout(RZout), .MDRout(MDRout), .HILOout(HILOout),
        .INPUTout(INPUTout), .BAout(BAout), .Cout(Cout),
        .Read(Read), .mem_write(mem_write), .alu_ctrl(alu_ctrl), .halted(halted)
    );

    always #5 clk = ~clk;

    outs_t act;
    assign act = {GPRin, GPRout, PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin,
                  PCout, RZout, MDRout, HILOout, INPUTout, BAout, Cout,
                  Read, mem_write, alu_ctrl, halted};

    int n_checks = 0;
    int n_errs   = 0;

    step_t mq[$];
    bit    m_valid = 0;
    bit    m_halt  = 0;
    bit    m_t0    = 0;
    outs_t tr [0:127];

    function automatic logic [15:0] oh(input logic [3:0] r);
        logic [15:0] one;
        one = 16'h0001;
        return one << r;
    endfunction

    function automatic logic [12:0] alu_bit(input int pos);
        logic [12:0] one;
        one = 13'h0001;
        return one << pos;
    endfunction

    function automatic logic [12:0] alu_for(input int op);
        case (op)
            0, 1, 2, 3, 11: return alu_bit(A_ADD);
            4:              return alu_bit(A_SUB);
            5, 12:          return alu_bit(A_AND);
            6, 13:          return alu_bit(A_OR);
            7:              return alu_bit(A_ROR);
            8:              return alu_bit(A_ROL);
            9:              return alu_bit(A_SHR);
            10:             return alu_bit(A_SHL);
            14:             return alu_bit(A_MUL);
            15:             return alu_bit(A_DIV);
            16:             return alu_bit(A_NEG);
            17:             return alu_bit(A_NOT);
            default:        return 13'h0;
        endcase
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int lo);
        logic [31:0] v;
        v = {op[4:0], ra[3:0], rb[3:0], lo[18:0]};
        return v;
    endfunction

    task automatic push(input outs_t o, input bit wt, input int tag);
        step_t s;
        s.o = o; s.wt = wt; s.tag = tag;
        mq.push_back(s);
    endtask

    task automatic push_fetch();
        outs_t o;
        o = '0; o.pcout = 1; o.marin = 1; o.alu = alu_bit(A_INC); o.rzin = 1; push(o, 0, 1);
        o = '0; o.rzout = 1; o.pcin = 1; o.rd = 1; o.mdrin = 1;              push(o, 1, 0);
        o = '0; o.mdrout = 1; o.irin = 1;                                    push(o, 0, 2);
    endtask

    // Register-transfer steps per instruction class
    task automatic push_exec(input logic [31:0] ir);
        int op;
        logic [15:0] a, b, c;
        outs_t o;
        op = int'(ir[31:27]);
        a = oh(ir[26:23]); b = oh(ir[22:19]); c = oh(ir[18:15]);
        if (op >= 3 && op <= 13) begin
            o = '0; o.gout = b; o.ryin = 1; push(o, 0, 0);
            o = '0; if (op <= 10) o.gout = c; else o.cout = 1;
            o.alu = alu_for(op); o.rzin = 1; push(o, 0, 0);
            o = '0; o.rzout = 1; o.gin = a; push(o, 0, 0);
        end else if (op == 14 || op == 15) begin
            o = '0; o.gout = a; o.ryin = 1; push(o, 0, 0);
            o = '0; o.gout = b; o.alu = alu_for(op); o.rzin = 1; push(o, 0, 0);
            o = '0; o.rzout = 1; o.hiloin = 1; push(o, 0, 0);
        end else if (op == 16 || op == 17) begin
            o = '0; o.gout = b; o.alu = alu_for(op); o.rzin = 1; push(o, 0, 0);
            o = '0; o.rzout = 1; o.gin = a; push(o, 0, 0);
        end else if (op <= 2) begin
            o = '0; o.gout = b; o.baout = 1; o.ryin = 1; push(o, 0, 0);
            o = '0; o.cout = 1; o.alu = alu_bit(A_ADD); o.rzin = 1; push(o, 0, 0);
            if (op == 1) begin
                o = '0; o.rzout = 1; o.gin = a; push(o, 0, 0);
            end else begin
                o = '0; o.rzout = 1; o.marin = 1; push(o, 0, 0);
                if (op == 0) begin
                    o = '0; o.rd = 1; o.mdrin = 1;   push(o, 1, 0);
                    o = '0; o.mdrout = 1; o.gin = a; push(o, 0, 0);
                end else begin
                    o = '0; o.gout = a; o.mdrin = 1; push(o, 0, 0);
                    o = '0; o.mw = 1;                push(o, 1, 0);
                end
            end
        end else if (op == 22) begin
            o = '0; o.inpout = 1; o.gin = a; push(o, 0, 0);
        end else if (op == 23) begin
            o = '0; o.gout = a; o.outin = 1; push(o, 0, 0);
        end
    endtask

    initial begin : model
        step_t h;
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                push_fetch();
                m_halt  = 0;
                m_valid = 1;
            end else if (m_valid && !m_halt) begin
                h = mq[0];
                if (!h.wt || mem_ready) begin
                    h = mq.pop_front();
                    if (h.tag == 2) begin
                        if (IRVal[31:27] == 5'd27) begin
                            m_halt = 1;
                            mq.delete();
                        end else begin
                            push_exec(IRVal);
                        end
                    end
                    if (!m_halt && mq.size() == 0) push_fetch();
                end
            end
            m_t0 = m_valid && !m_halt && (mq.size() > 0) && (mq[0].tag == 1);
        end
    end

    initial begin : compare
        outs_t e;
        forever begin
            @(negedge clk);
            if (reset || m_valid) begin
                e = '0;
                if (!reset) begin
                    if (m_halt) e.halted = 1;
                    else        e = mq[0].o;
                end
                n_checks++;
                if (act !== e) begin
                    n_errs++;
                    $display("FAIL model_cycle t=%0t act=%h exp=%h", $time, act, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_errs++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    // One-cycle reset, then ncyc traced cycles; mem_ready low on cycles [st_from, st_from+st_len)
    task automatic run_seq(input logic [31:0] ir, input int ncyc, input int st_from, input int st_len);
        @(posedge clk); #2;
        reset = 1'b1; IRVal = ir;
        @(negedge clk);
        chk("reset_zero", 64'(act), 64'h0);
        @(posedge clk); #2;
        reset = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            mem_ready = (k >= st_from && k < st_from + st_len) ? 1'b0 : 1'b1;
            @(negedge clk);
            tr[k] = act;
            @(posedge clk); #2;
        end
        mem_ready = 1'b1;
    endtask

    initial begin : main
        int cnt, hc;
        int op;
        outs_t hz;
        hz = '0; hz.halted = 1;

        // add R3,R1,R2
        run_seq(mk_ir(3, 3, 1, 2 << 15), 7, 99, 0);
        chk("t0_fetch", {tr[0].pcout, tr[0].marin, tr[0].rzin, tr[0].alu}, {3'b111, 13'h1000});
        chk("t1_fetch", {tr[1].rzout, tr[1].pcin, tr[1].rd, tr[1].mdrin}, 4'b1111);
        chk("t2_fetch", {tr[2].mdrout, tr[2].irin}, 2'b11);
        chk("add_t3", {tr[3].gout, tr[3].ryin}, {16'h0002, 1'b1});
        chk("add_t4", {tr[4].gout, tr[4].alu, tr[4].rzin}, {16'h0004, 13'h0001, 1'b1});
        chk("add_t5", {tr[5].gin, tr[5].rzout}, {16'h0008, 1'b1});
        chk("add_back_t0", tr[6].pcout, 1);

        // ld R1,0x10(R0) with three wait cycles in T6
        run_seq(mk_ir(0, 1, 0, 16), 12, 6, 3);
        cnt = 0;
        for (int k = 6; k <= 10; k++) if (tr[k].rd && tr[k].mdrin) cnt++;
        chk("ld_read_hold", cnt, 4);
        chk("ld_t7", {tr[10].gin, tr[10].mdrout}, {16'h0002, 1'b1});
        cnt = 0;
        for (int k = 0; k < 12; k++) if (tr[k].baout) cnt++;
        chk("ld_baout_once", {tr[3].baout, 8'(cnt), tr[3].gout}, {1'b1, 8'd1, 16'h0001});
        chk("ld_t4", {tr[4].cout, tr[4].alu}, {1'b1, 13'h0001});
        chk("ld_back_t0", tr[11].pcout, 1);

        // st R2,5(R4) with two wait cycles in T7
        run_seq(mk_ir(2, 2, 4, 5), 11, 7, 2);
        chk("st_t6", {tr[6].gout, tr[6].mdrin, tr[6].rd}, {16'h0004, 2'b10});
        cnt = 0;
        for (int k = 0; k < 11; k++) if (tr[k].mw) cnt++;
        chk("st_write_hold", cnt, 3);
        cnt = 0;
        for (int k = 0; k < 11; k++) if (tr[k].gin != 0) cnt++;
        chk("st_no_gprin", cnt, 0);
        chk("st_back_t0", tr[10].pcout, 1);

        // mul R5,R6
        run_seq(mk_ir(14, 5, 6, 0), 7, 99, 0);
        chk("mul_t3", tr[3].gout, 16'h0020);
        chk("mul_t4", {tr[4].gout, tr[4].alu}, {16'h0040, 13'h0004});
        chk("mul_t5", {tr[5].rzout, tr[5].hiloin, tr[5].gin}, {2'b11, 16'h0});

        // halt holds for 100 cycles
        run_seq(mk_ir(27, 0, 0, 0), 103, 99, 0);
        cnt = 0;
        for (int k = 3; k < 103; k++) if (tr[k] === hz) cnt++;
        chk("halt_hold", cnt, 100);

        // ld stuck in T6, then reset; next run checks reset exits cleanly to T0
        run_seq(mk_ir(0, 1, 0, 16), 8, 6, 10);
        chk("ld_stuck_t6", {tr[7].rd, tr[7].mdrin}, 2'b11);
        mem_ready = 1'b0;
        run_seq(mk_ir(31, 0, 0, 0), 5, 99, 0);
        chk("reset_to_t0", {tr[0].pcout, tr[0].marin}, 2'b11);
        chk("undef_t2", tr[2].mdrout, 1);
        chk("undef_to_t0", {tr[3].pcout, tr[3].gout, tr[3].gin}, {1'b1, 32'h0});

        // randomized phase: new instruction whenever a fetch begins
        hc = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_t0) begin
                op = $urandom_range(0, 31);
                if (op == 27 && $urandom_range(0, 3) != 0) op = 3;
                IRVal = {op[4:0], 27'($urandom)};
            end
            if (m_halt) hc++;
            reset = ($urandom_range(0, 149) == 0) || (hc > 5);
            if (reset) hc = 0;
            @(posedge clk); #2;
        end
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
